muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand and result width.
REQ-002 Parameter ADDRESS_WIDTH, default 5, SHALL set the destination register tag width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new operation; it is sampled only in IDLE.
REQ-006 funct3  input  3  SHALL select the RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  DATA_WIDTH  SHALL carry rs1 data (regfile RD1).
REQ-008 op_b  input  DATA_WIDTH  SHALL carry rs2 data (regfile RD2).
REQ-009 rd_in  input  ADDRESS_WIDTH  SHALL carry the destination register tag.
REQ-010 busy  output  1  SHALL be high while an operation is in flight (CALC or DONE).
REQ-011 done  output  1  SHALL pulse high for exactly one cycle when result is valid; it drives regfile WE3.
REQ-012 result  output  DATA_WIDTH  SHALL carry the op result; it drives regfile WD3.
REQ-013 rd_out  output  ADDRESS_WIDTH  SHALL carry the latched rd_in; it drives regfile AD3.

Function
REQ-014 FSM states SHALL be IDLE, CALC, DONE; IDLE->CALC on start, unless a special case applies (REQ-019/020), in which case IDLE->DONE.
REQ-015 On accept, op_a, op_b, funct3 and rd_in SHALL be latched; later input changes SHALL not affect the operation.
REQ-016 CALC SHALL run exactly DATA_WIDTH iterations, using a 6-bit counter, one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle; then CALC->DONE.
REQ-017 Start accepted at edge 0 SHALL produce done=1 during the cycle after edge DATA_WIDTH+1 (33 cycles); DONE->IDLE unconditionally after one cycle.
REQ-018 Signed ops SHALL operate on operand magnitudes and negate at finish:
  - products: negate when operand signs differ (MULHSU treats op_b as unsigned);
  - quotient: negate when signs differ;
  - remainder: takes the sign of op_a.
  MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-019 Divide by zero SHALL go directly to DONE with done after 1 cycle: DIV/DIVU result 0xFFFFFFFF; REM/REMU result op_a.
REQ-020 DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF SHALL go directly to DONE: DIV result 0x80000000, REM result 0.
REQ-021 start while busy=1 SHALL be ignored with no effect on the in-flight operation.
REQ-022 start in the same cycle as the done pulse SHALL be ignored; start is accepted from the next IDLE cycle onward.
REQ-023 result and rd_out SHALL hold their last values until the next done pulse.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, rd_out=0 and the counter to 0, including mid-CALC.
REQ-025 rst SHALL take priority over start in the same cycle; an interrupted operation SHALL produce no done pulse.

Structure
REQ-026 Package muldiv_pkg SHALL hold the funct3 op enum, the FSM state enum and the DATA_WIDTH/ADDRESS_WIDTH defaults.
REQ-027 The block SHALL be a single module with no sub-module; datapath and FSM share one always_ff plus one always_comb.

Verification
REQ-028 MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, done at cycle 33, busy high cycles 1-33, rd_out=rd_in.
REQ-029 MULHU op_a=op_b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-030 DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-031 DIVU op_a=5, op_b=0 -> result 0xFFFFFFFF, done at cycle 1; REMU with the same operands -> 5.
REQ-032 DIV op_a=0x80000000, op_b=0xFFFFFFFF -> result 0x80000000 after 1 cycle; REM with the same operands -> 0.
REQ-033 start pulsed at cycle 5 of a MUL -> ignored, original result returned; rst at cycle 10 of a DIV -> next cycle busy=0, result=0, no done pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and width defaults for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int DATA_WIDTH_DEF    = 32;
    localparam int ADDRESS_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH    = muldiv_pkg::DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = muldiv_pkg::ADDRESS_WIDTH_DEF
);
    logic                     start;
    logic [2:0]               funct3;
    logic [DATA_WIDTH-1:0]    op_a;
    logic [DATA_WIDTH-1:0]    op_b;
    logic [ADDRESS_WIDTH-1:0] rd_in;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    result;
    logic [ADDRESS_WIDTH-1:0] rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: sign-magnitude operands, one radix-2
// shift-add or restoring shift-subtract step per cycle, sign fix-up at finish.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
    input logic         clk,
    input logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam logic [5:0] LAST_ITER = 6'(DATA_WIDTH);

    state_t                   r_state;
    logic [5:0]               r_cnt;
    op_t                      r_op;
    logic                     r_neg;
    logic [DW-1:0]            r_hi;
    logic [DW-1:0]            r_lo;
    logic [DW-1:0]            r_d;
    logic [ADDRESS_WIDTH-1:0] r_rd;
    logic [DW-1:0]            r_result;
    logic [ADDRESS_WIDTH-1:0] r_rd_out;

    op_t           w_f;
    logic          w_is_div;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [DW-1:0] w_a_mag;
    logic [DW-1:0] w_b_mag;
    logic          w_neg;
    logic          w_div0;
    logic          w_ovf;
    logic [DW-1:0] w_special;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_shift;
    logic          w_ge;
    logic [DW-1:0] w_diff;
    logic [2*DW-1:0] w_prod_raw;
    logic [2*DW-1:0] w_prod;
    logic [DW-1:0] w_quo;
    logic [DW-1:0] w_rem;
    logic [DW-1:0] w_final;

    always_comb begin
        w_f      = op_t'(bus.funct3);
        w_is_div = bus.funct3[2];
        w_a_neg  = (w_f inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.op_a[DW-1];
        w_b_neg  = (w_f inside {OP_MULH, OP_DIV, OP_REM}) && bus.op_b[DW-1];
        w_a_mag  = w_a_neg ? -bus.op_a : bus.op_a;
        w_b_mag  = w_b_neg ? -bus.op_b : bus.op_b;
        // Remainder follows the dividend's sign; everything else the sign product.
        w_neg    = (w_f inside {OP_REM, OP_REMU}) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div0   = w_is_div && (bus.op_b == '0);
        w_ovf    = (w_f inside {OP_DIV, OP_REM}) &&
                   (bus.op_a == {1'b1, {(DW-1){1'b0}}}) && (bus.op_b == '1);
        w_special = '0;
        if (w_div0)
            w_special = bus.funct3[1] ? bus.op_a : '1;
        else if (w_ovf)
            w_special = bus.funct3[1] ? '0 : bus.op_a;

        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
        w_shift = {r_hi, r_lo[DW-1]};
        w_ge    = w_shift >= {1'b0, r_d};
        w_diff  = w_shift[DW-1:0] - r_d;

        w_prod_raw = {r_hi, r_lo};
        w_prod     = r_neg ? -w_prod_raw : w_prod_raw;
        w_quo      = r_neg ? -r_lo : r_lo;
        w_rem      = r_neg ? -r_hi : r_hi;
        case (r_op)
            OP_MUL:                     w_final = w_prod[DW-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*DW-1:DW];
            OP_DIV, OP_DIVU:            w_final = w_quo;
            default:                    w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_d      <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_op  <= w_f;
                    r_rd  <= bus.rd_in;
                    r_neg <= w_neg;
                    r_cnt <= '0;
                    r_hi  <= '0;
                    if (w_div0 || w_ovf) begin
                        r_result <= w_special;
                        r_rd_out <= bus.rd_in;
                        r_state  <= DONE;
                    end else begin
                        // Divide: dividend shifts out of r_lo; multiply: multiplier does.
                        r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                        r_d     <= w_is_div ? w_b_mag : w_a_mag;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt == LAST_ITER) begin
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_op[2]) begin
                            r_hi <= w_ge ? w_diff : w_shift[DW-1:0];
                            r_lo <= {r_lo[DW-2:0], w_ge};
                        end else begin
                            r_hi <= w_sum[DW:1];
                            r_lo <= {w_sum[0], r_lo[DW-1:1]};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random RV32M ops against a 64-bit arithmetic model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb_ = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb_; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb_; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 0;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    // Monitor: pops on every done pulse; otherwise outputs must hold.
    logic [31:0] last_res  = '0;
    logic [4:0]  last_rd   = '0;
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    int unsigned run       = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_res = '0;
            last_rd  = '0;
            run      = 0;
        end else begin
            if (bus.busy) run = prev_busy ? run + 1 : 0;
            if (bus.done) begin
                chk("done_single_pulse", 64'(prev_done), 64'd0);
                chk("busy_with_done", 64'(bus.busy), 64'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(bus.result), 64'(e.res));
                    chk("rd_out", 64'(bus.rd_out), 64'(e.rd));
                    chk("latency", 64'(run), 64'(e.lat));
                    last_res = e.res;
                    last_rd  = e.rd;
                end
            end else begin
                chk("hold", {27'b0, bus.rd_out, bus.result}, {27'b0, last_rd, last_res});
            end
        end
        prev_busy = bus.busy;
        prev_done = bus.done;
    end

    task automatic scramble();
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        int unsigned w = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0) begin
            @(negedge clk);
            w++;
            if (w > 200) begin
                chk("idle_timeout", 64'(bus.busy), 64'd0);
                break;
            end
        end
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        e.res = model(f, a, b);
        e.rd  = rd;
        e.lat = model_lat(f, a, b);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic wait_done();
        int unsigned w = 0;
        while (bus.done !== 1'b1) begin
            @(negedge clk);
            w++;
            if (w > 200) begin
                chk("done_timeout", 64'(bus.done), 64'd1);
                break;
            end
        end
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        exp_t        e;
        int unsigned w;

        bus.start = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_done",   64'(bus.done),   64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_rd_out", 64'(bus.rd_out), 64'd0);
        rst = 1'b0;

        issue(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7);
        issue(3'd5, 32'd5,         32'd0,         5'd8);
        issue(3'd7, 32'd5,         32'd0,         5'd9);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // start pulsed while busy must not disturb the running MUL
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        scramble();
        @(negedge clk);
        bus.start = 1'b0;

        // start raised during the done cycle is accepted only on the following IDLE cycle
        wait_done();
        bus.start  = 1'b1;
        bus.funct3 = 3'd5;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        bus.rd_in  = 5'd14;
        e.res = model(3'd5, 32'd100, 32'd7);
        e.rd  = 5'd14;
        e.lat = 33;
        sb.push_back(e);
        @(negedge clk);
        chk("start_in_done_ignored", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        scramble();

        // reset in the middle of a DIV: no done pulse may follow
        issue(3'd4, 32'd1000, 32'd3, 5'd15);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy",   64'(bus.busy),   64'd0);
        chk("midrst_done",   64'(bus.done),   64'd0);
        chk("midrst_result", 64'(bus.result), 64'd0);
        chk("midrst_rd_out", 64'(bus.rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        for (int unsigned i = 0; i < 150; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 9)); end
                3: b = 32'($urandom_range(1, 255));
                default: ;
            endcase
            issue(f, a, b, 5'($urandom));
        end

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
